// File: rtl/ew_fifo_s1_flex.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : ew_fifo_s1_flex                                                |
// | Purpose  : Single-clock synchronous FIFO with any depth (2..1024),        |
// |            run-time almost-empty / almost-full thresholds, standard or    |
// |            first-word-fall-through read mode, live word count and         |
// |            register-array storage.                                        |
// | Ports    : clk, rst (sync, active-high)                                   |
// |            push_req_n / pop_req_n  active-low write / read requests       |
// |            data_in                 write data                             |
// |            ae_level, af_thresh     almost-empty level, almost-full        |
// |                                    distance from full                     |
// |            empty, almost_empty, half_full, almost_full, full, error       |
// |            word_count              current occupancy                      |
// |            data_out                read data                              |
// |            peak_count              high-water mark (EW_FIFO_PEAK_EN only) |
// | Options  : define EW_FIFO_PEAK_EN to add the peak_count output.           |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module ew_fifo_s1_flex #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 8,
  parameter int ERR_MODE   = 0,
  parameter int FWFT       = 0,
  parameter int CNT_WIDTH  = $clog2(RAM_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_req_n,
  input  logic                  pop_req_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CNT_WIDTH-1:0]  ae_level,
  input  logic [CNT_WIDTH-1:0]  af_thresh,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  half_full,
  output logic                  almost_full,
  output logic                  full,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  word_count,
`ifdef EW_FIFO_PEAK_EN
  output logic [CNT_WIDTH-1:0]  peak_count,
`endif
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int                   PTR_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(RAM_DEPTH);
  localparam logic [CNT_WIDTH-1:0] HALF_C    = CNT_WIDTH'((RAM_DEPTH + 1) / 2);

  logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;

  logic                  pop_ok;
  logic                  push_ok;
  logic                  overflow;
  logic                  underflow;
  logic [CNT_WIDTH-1:0]  count_next;
  logic                  af_next;

  always_comb begin
    pop_ok     = !pop_req_n && !empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    push_ok    = !push_req_n && (!full || pop_ok);
    overflow   = !push_req_n && full && !pop_ok;
    underflow  = !pop_req_n && empty;
    count_next = word_count;
    if (push_ok && !pop_ok) begin
      count_next = word_count + CNT_WIDTH'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = word_count - CNT_WIDTH'(1);
    end
    // Saturating subtraction: a threshold at or beyond the depth pins the flag high.
    af_next = 1'b1;
    if (af_thresh < DEPTH_C) begin
      af_next = (count_next >= (DEPTH_C - af_thresh));
    end
  end

  // Pointers wrap with an explicit compare so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_WIDTH'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_WIDTH'(1);
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Flags are registered from the next count so they line up with word_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count   <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      half_full    <= 1'b0;
      almost_full  <= 1'b0;
      full         <= 1'b0;
      error        <= 1'b0;
    end else begin
      word_count   <= count_next;
      empty        <= (count_next == '0);
      almost_empty <= (count_next <= ae_level);
      half_full    <= (count_next >= HALF_C);
      almost_full  <= af_next;
      full         <= (count_next == DEPTH_C);
      if (ERR_MODE == 0) begin
        error <= error | overflow | underflow;
      end else begin
        error <= overflow | underflow;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; meaningless while empty.
      assign data_out = mem[rd_ptr];
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst) begin
          data_out <= '0;
        end else if (pop_ok) begin
          // Reads the pre-edge contents, so a simultaneous write to the
          // same slot on a full FIFO returns the old word.
          data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

`ifdef EW_FIFO_PEAK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_count <= '0;
    end else if (count_next > peak_count) begin
      peak_count <= count_next;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ew_fifo_s1_flex.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_ew_fifo_s1_flex                                             |
// | Purpose  : Self-checking bench for ew_fifo_s1_flex. Three instances:      |
// |            A depth 8 standard sticky-error, B depth 5 pulse-error,        |
// |            C depth 8 first-word-fall-through.                             |
// | Ports    : none                                                           |
// | Options  : EW_FIFO_PEAK_EN adds the high-water-mark checks.               |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module tb_ew_fifo_s1_flex;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A
  logic        a_push_n, a_pop_n;
  logic [31:0] a_din, a_dout;
  logic [3:0]  a_ae, a_af, a_cnt;
  logic        a_empty, a_aef, a_hf, a_aff, a_full, a_err;
  // instance B
  logic        b_push_n, b_pop_n;
  logic [31:0] b_din, b_dout;
  logic [2:0]  b_ae, b_af, b_cnt;
  logic        b_empty, b_aef, b_hf, b_aff, b_full, b_err;
  // instance C
  logic        c_push_n, c_pop_n;
  logic [31:0] c_din, c_dout;
  logic [3:0]  c_ae, c_af, c_cnt;
  logic        c_empty, c_aef, c_hf, c_aff, c_full, c_err;
`ifdef EW_FIFO_PEAK_EN
  logic [3:0]  a_peak, c_peak;
  logic [2:0]  b_peak;
`endif

  ew_fifo_s1_flex #(.DATA_WIDTH(32), .RAM_DEPTH(8), .ERR_MODE(0), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .push_req_n(a_push_n), .pop_req_n(a_pop_n),
    .data_in(a_din), .ae_level(a_ae), .af_thresh(a_af),
    .empty(a_empty), .almost_empty(a_aef), .half_full(a_hf),
    .almost_full(a_aff), .full(a_full), .error(a_err), .word_count(a_cnt),
`ifdef EW_FIFO_PEAK_EN
    .peak_count(a_peak),
`endif
    .data_out(a_dout));

  ew_fifo_s1_flex #(.DATA_WIDTH(32), .RAM_DEPTH(5), .ERR_MODE(1), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .push_req_n(b_push_n), .pop_req_n(b_pop_n),
    .data_in(b_din), .ae_level(b_ae), .af_thresh(b_af),
    .empty(b_empty), .almost_empty(b_aef), .half_full(b_hf),
    .almost_full(b_aff), .full(b_full), .error(b_err), .word_count(b_cnt),
`ifdef EW_FIFO_PEAK_EN
    .peak_count(b_peak),
`endif
    .data_out(b_dout));

  ew_fifo_s1_flex #(.DATA_WIDTH(32), .RAM_DEPTH(8), .ERR_MODE(0), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .push_req_n(c_push_n), .pop_req_n(c_pop_n),
    .data_in(c_din), .ae_level(c_ae), .af_thresh(c_af),
    .empty(c_empty), .almost_empty(c_aef), .half_full(c_hf),
    .almost_full(c_aff), .full(c_full), .error(c_err), .word_count(c_cnt),
`ifdef EW_FIFO_PEAK_EN
    .peak_count(c_peak),
`endif
    .data_out(c_dout));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // {empty, almost_empty, half_full, almost_full, full} for depth 8, ae=2, af=2
  function automatic logic [4:0] fl(input int cnt);
    case (cnt)
      0:       fl = 5'b11000;
      1, 2:    fl = 5'b01000;
      3:       fl = 5'b00000;
      4, 5:    fl = 5'b00100;
      6, 7:    fl = 5'b00110;
      default: fl = 5'b00111;
    endcase
  endfunction

  typedef struct {
    logic        push_n;
    logic        pop_n;
    logic [31:0] din;
    logic [4:0]  flags;
    logic        err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic pn, input logic popn, input logic [31:0] d,
                     input int cnt, input logic e);
    vec_t v;
    v.push_n = pn; v.pop_n = popn; v.din = d; v.flags = fl(cnt); v.err = e;
    tbl.push_back(v);
  endtask

  // Scoreboards: model contents and expected read data
  logic [31:0] a_model[$], a_exp[$], b_model[$], b_exp[$];

  task automatic a_cycle(input logic pn, input logic popn, input logic [31:0] d);
    bit pop_ok, push_ok;
    a_push_n = pn; a_pop_n = popn; a_din = d;
    pop_ok  = !popn && (a_model.size() > 0);
    push_ok = !pn && ((a_model.size() < 8) || pop_ok);
    if (pop_ok)  a_exp.push_back(a_model.pop_front());
    if (push_ok) a_model.push_back(d);
    @(posedge clk); #1;
    a_push_n = 1'b1; a_pop_n = 1'b1;
    chk("a_count", 32'(a_cnt), 32'(a_model.size()));
    if (a_exp.size() > 0) chk("a_data", a_dout, a_exp.pop_front());
  endtask

  task automatic b_cycle(input logic pn, input logic popn, input logic [31:0] d);
    bit pop_ok, push_ok;
    b_push_n = pn; b_pop_n = popn; b_din = d;
    pop_ok  = !popn && (b_model.size() > 0);
    push_ok = !pn && ((b_model.size() < 5) || pop_ok);
    if (pop_ok)  b_exp.push_back(b_model.pop_front());
    if (push_ok) b_model.push_back(d);
    @(posedge clk); #1;
    b_push_n = 1'b1; b_pop_n = 1'b1;
    chk("b_count", 32'(b_cnt), 32'(b_model.size()));
    if (b_exp.size() > 0) chk("b_data", b_dout, b_exp.pop_front());
  endtask

  task automatic c_cycle(input logic pn, input logic popn, input logic [31:0] d);
    c_push_n = pn; c_pop_n = popn; c_din = d;
    @(posedge clk); #1;
    c_push_n = 1'b1; c_pop_n = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a_model.delete(); a_exp.delete(); b_model.delete(); b_exp.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_push_n = 1'b1; a_pop_n = 1'b1; a_din = '0; a_ae = 4'd2; a_af = 4'd2;
    b_push_n = 1'b1; b_pop_n = 1'b1; b_din = '0; b_ae = 3'd1; b_af = 3'd1;
    c_push_n = 1'b1; c_pop_n = 1'b1; c_din = '0; c_ae = 4'd2; c_af = 4'd2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

`ifdef EW_FIFO_PEAK_EN
    for (int i = 0; i < 6; i++) a_cycle(1'b0, 1'b1, 32'h40 + 32'(i));
    for (int i = 0; i < 6; i++) a_cycle(1'b1, 1'b0, 32'h0);
    chk("a_peak_after_fill6", 32'(a_peak), 32'd6);
    do_reset();
    chk("a_peak_after_rst", 32'(a_peak), 32'd0);
`endif

    // Reset state
    chk("a_rst_flags", {27'd0, a_empty, a_aef, a_hf, a_aff, a_full}, 32'b11000);
    chk("a_rst_err", 32'(a_err), 32'd0);
    chk("a_rst_count", 32'(a_cnt), 32'd0);
    chk("a_rst_dout", a_dout, 32'd0);
    chk("b_rst_empty", 32'(b_empty), 32'd1);
    chk("b_rst_err", 32'(b_err), 32'd0);
    chk("c_rst_empty", 32'(c_empty), 32'd1);

    // Instance A vector table: fill, overflow, drain, underflow, refill,
    // full push+pop, drain.
    for (int i = 1; i <= 9; i++) add(1'b0, 1'b1, 32'(i), (i > 8) ? 8 : i, i == 9);
    for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 32'h0, 8 - i, 1'b1);
    add(1'b1, 1'b0, 32'h0, 0, 1'b1);
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 32'h11 + 32'(i), i + 1, 1'b1);
    add(1'b0, 1'b0, 32'h19, 8, 1'b1);
    for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 32'h0, 7 - i, 1'b1);

    foreach (tbl[k]) begin
      a_cycle(tbl[k].push_n, tbl[k].pop_n, tbl[k].din);
      chk($sformatf("a_flags[%0d]", k), {27'd0, a_empty, a_aef, a_hf, a_aff, a_full},
          {27'd0, tbl[k].flags});
      chk($sformatf("a_err[%0d]", k), 32'(a_err), 32'(tbl[k].err));
    end

    // Run-time thresholds: af_thresh beyond depth saturates, ae_level 0
    a_af = 4'd9;
    a_cycle(1'b1, 1'b1, 32'h0);
    chk("a_af_saturate", 32'(a_aff), 32'd1);
    a_af = 4'd2;
    a_cycle(1'b1, 1'b1, 32'h0);
    chk("a_af_restore", 32'(a_aff), 32'd0);
    a_ae = 4'd0;
    a_cycle(1'b0, 1'b1, 32'hAB);
    chk("a_ae0_cnt1", 32'(a_aef), 32'd0);
    a_cycle(1'b1, 1'b0, 32'h0);
    chk("a_ae0_cnt0", 32'(a_aef), 32'd1);

    // Instance B: depth-5 wrap, count never above 1
    for (int k = 0; k < 13; k++) begin
      b_cycle(1'b0, 1'b1, 32'h100 + 32'(k));
      chk("b_cnt_max1", 32'(b_cnt <= 3'd1), 32'd1);
      b_cycle(1'b1, 1'b0, 32'h0);
    end
    // Empty: push and pop together -> push accepted, one-cycle error pulse
    b_cycle(1'b0, 1'b0, 32'h77);
    chk("b_pp_empty_err", 32'(b_err), 32'd1);
    chk("b_pp_empty_flag", 32'(b_empty), 32'd0);
    b_cycle(1'b1, 1'b1, 32'h0);
    chk("b_err_pulse_end", 32'(b_err), 32'd0);
    b_cycle(1'b1, 1'b0, 32'h0);
    chk("b_err_after_pop", 32'(b_err), 32'd0);
    // Overflow on depth 5
    for (int k = 0; k < 5; k++) b_cycle(1'b0, 1'b1, 32'h200 + 32'(k));
    chk("b_full", 32'(b_full), 32'd1);
    b_cycle(1'b0, 1'b1, 32'h2FF);
    chk("b_ovf_err", 32'(b_err), 32'd1);
    b_cycle(1'b1, 1'b1, 32'h0);
    chk("b_ovf_err_end", 32'(b_err), 32'd0);
    for (int k = 0; k < 5; k++) b_cycle(1'b1, 1'b0, 32'h0);
    chk("b_drained_empty", 32'(b_empty), 32'd1);

    // Instance C: first-word-fall-through
    c_cycle(1'b0, 1'b1, 32'hA5);
    chk("c_fwft_head", c_dout, 32'hA5);
    chk("c_fwft_not_empty", 32'(c_empty), 32'd0);
    c_cycle(1'b1, 1'b0, 32'h0);
    chk("c_pop_empty", 32'(c_empty), 32'd1);
    chk("c_pop_count", 32'(c_cnt), 32'd0);
    c_cycle(1'b0, 1'b1, 32'h5A);
    c_cycle(1'b0, 1'b1, 32'h3C);
    chk("c_head_first", c_dout, 32'h5A);
    c_cycle(1'b1, 1'b0, 32'h0);
    chk("c_head_next", c_dout, 32'h3C);
    chk("c_count_1", 32'(c_cnt), 32'd1);
    c_cycle(1'b1, 1'b0, 32'h0);
    chk("c_final_empty", 32'(c_empty), 32'd1);
    chk("c_err_none", 32'(c_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
